// File: rtl/display_scanner.sv
// Multiplexes a 16-bit hex value onto a shared nibble bus with one-hot digit enables.
// Value changes take effect only at frame boundaries. Digits can be blanked between slots.
module display_scanner #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Value,
  input  logic        Load,
  input  logic        Enable,
  input  logic        LzEn,
  output logic        Out0,
  output logic        Out1,
  output logic        Out2,
  output logic        Out3,
  output logic [3:0]  DigitEn,
  output logic        FrameDone
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StShow = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GapLast   = (GAP == 0) ? '0 : CNT_W'(GAP - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      pending_q, pending_d;
  logic             flag_q, flag_d;
  logic [3:0]       nibble_q, nibble_d;
  logic [3:0]       digit_en_q, digit_en_d;
  logic             frame_done_q;
  logic             wrap;
  logic             commit;
  logic [3:0]       lz_blank;

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    if (!Enable) begin
      state_d = StIdle;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StShow;
          digit_d = '0;
          cnt_d   = '0;
        end
        StShow: begin
          if (cnt_q == DwellLast) begin
            cnt_d = '0;
            if (GAP == 0) begin
              digit_d = digit_q + 2'd1;
              wrap    = (digit_q == 2'd3);
            end else begin
              state_d = StGap;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            state_d = StShow;
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            wrap    = (digit_q == 2'd3);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A Load on a commit edge lands in pending and stays flagged for the next commit.
  always_comb begin
    commit    = (state_q == StIdle) || wrap;
    pending_d = Load ? Value : pending_q;
    flag_d    = Load | (flag_q & ~commit);
    active_d  = (commit && flag_q) ? pending_q : active_q;
  end

  // Outputs are registered, so they are derived from the post-edge state and value.
  always_comb begin
    lz_blank[0] = 1'b0;
    lz_blank[1] = LzEn & ~|active_d[15:4];
    lz_blank[2] = LzEn & ~|active_d[15:8];
    lz_blank[3] = LzEn & ~|active_d[15:12];
    nibble_d    = nibble_q;
    digit_en_d  = '0;
    if (state_d == StShow) begin
      nibble_d = 4'(active_d >> {digit_d, 2'b00});
      if (!lz_blank[digit_d]) begin
        digit_en_d = 4'b0001 << digit_d;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      digit_q      <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      flag_q       <= 1'b0;
      nibble_q     <= '0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      flag_q       <= flag_d;
      nibble_q     <= nibble_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= wrap;
    end
  end

  assign Out0      = nibble_q[3];
  assign Out1      = nibble_q[2];
  assign Out2      = nibble_q[1];
  assign Out3      = nibble_q[0];
  assign DigitEn   = digit_en_q;
  assign FrameDone = frame_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: a GAP=1 and a GAP=0 build share stimulus and are
// checked against a slot-arithmetic reference model.
module tb_display_scanner;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Value;
  logic        Load;
  logic        Enable;
  logic        LzEn;

  logic       a_o0, a_o1, a_o2, a_o3, a_fd;
  logic [3:0] a_de;
  logic       b_o0, b_o1, b_o2, b_o3, b_fd;
  logic [3:0] b_de;

  display_scanner #(.DWELL(4), .GAP(1), .CNT_W(16)) u_dut_gap (
    .Clk(Clk), .Reset(Reset), .Value(Value), .Load(Load), .Enable(Enable), .LzEn(LzEn),
    .Out0(a_o0), .Out1(a_o1), .Out2(a_o2), .Out3(a_o3), .DigitEn(a_de), .FrameDone(a_fd)
  );

  display_scanner #(.DWELL(4), .GAP(0), .CNT_W(16)) u_dut_nogap (
    .Clk(Clk), .Reset(Reset), .Value(Value), .Load(Load), .Enable(Enable), .LzEn(LzEn),
    .Out0(b_o0), .Out1(b_o1), .Out2(b_o2), .Out3(b_o3), .DigitEn(b_de), .FrameDone(b_fd)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    logic [3:0] de;
    logic [3:0] nib;
    logic       fd;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: position since enable, split into frame / digit slot / phase.
  bit          m_idle[2];
  int          m_t[2];
  logic [15:0] m_act[2];
  logic [15:0] m_pend[2];
  int          m_dw[2] = '{4, 4};
  int          m_gp[2] = '{1, 0};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_idle[i] = 1'b1;
      m_t[i]    = 0;
      m_act[i]  = '0;
      m_pend[i] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(input int i);
    int  period, frame, p, d, ph;
    bit  wrap, commit, lit;
    ev_t e;
    period = m_dw[i] + m_gp[i];
    frame  = 4 * period;
    wrap   = 1'b0;
    if (!Enable) begin
      commit    = m_idle[i];
      m_idle[i] = 1'b1;
    end else if (m_idle[i]) begin
      commit    = 1'b1;
      m_idle[i] = 1'b0;
      m_t[i]    = 0;
    end else begin
      m_t[i]++;
      wrap   = (m_t[i] % frame) == 0;
      commit = wrap;
    end
    if (commit) m_act[i] = m_pend[i];
    if (Load) m_pend[i] = Value;
    if (!m_idle[i]) begin
      p     = m_t[i] % frame;
      d     = p / period;
      ph    = p % period;
      e.cyc = cyc;
      e.nib = 4'((m_act[i] >> (4 * d)) & 16'hF);
      e.fd  = wrap;
      lit   = (ph < m_dw[i]) && !(LzEn && d > 0 && (m_act[i] >> (4 * d)) == 16'h0);
      e.de  = lit ? 4'(1 << d) : 4'b0000;
      if (e.de != 4'b0000 || e.fd) begin
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qhead_cyc(input int i);
    return (i == 0) ? q0[0].cyc : q1[0].cyc;
  endfunction

  function automatic ev_t qpop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic mon(input int i, input logic [3:0] de, input logic [3:0] nib, input logic fd);
    ev_t e;
    while (qsize(i) > 0 && qhead_cyc(i) < cyc) begin
      e = qpop(i);
      n_chk++;
      n_fail++;
      $display("FAIL dut%0d missed_event cyc=%0d: got dark, required de=%b nib=%h fd=%b",
               i, e.cyc, e.de, e.nib, e.fd);
    end
    if (de != 4'b0000 || fd) begin
      n_chk++;
      if (qsize(i) == 0) begin
        n_fail++;
        $display("FAIL dut%0d unexpected_event cyc=%0d: got de=%b nib=%h fd=%b, required dark",
                 i, cyc, de, nib, fd);
      end else begin
        e = qpop(i);
        if (e.cyc != cyc || e.de !== de || e.nib !== nib || e.fd !== fd) begin
          n_fail++;
          $display("FAIL dut%0d scan_event: got cyc=%0d de=%b nib=%h fd=%b, required cyc=%0d de=%b nib=%h fd=%b",
                   i, cyc, de, nib, fd, e.cyc, e.de, e.nib, e.fd);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (Reset === 1'b0) begin
        mon(0, a_de, {a_o0, a_o1, a_o2, a_o3}, a_fd);
        mon(1, b_de, {b_o0, b_o1, b_o2, b_o3}, b_fd);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_de_gap"},   int'(a_de), 0);
    chk({tag, "_nib_gap"},  int'({a_o0, a_o1, a_o2, a_o3}), 0);
    chk({tag, "_fd_gap"},   int'(a_fd), 0);
    chk({tag, "_de_nogap"}, int'(b_de), 0);
    chk({tag, "_nib_nogap"}, int'({b_o0, b_o1, b_o2, b_o3}), 0);
    chk({tag, "_fd_nogap"}, int'(b_fd), 0);
  endtask

  task automatic tick();
    @(posedge Clk);
    cyc++;
    if (!Reset) begin
      model_step(0);
      model_step(1);
    end
    @(negedge Clk);
    Load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic load(input logic [15:0] v);
    Value = v;
    Load  = 1'b1;
    tick();
  endtask

  logic [15:0] rv;

  initial begin
    Reset  = 1'b1;
    Value  = '0;
    Load   = 1'b0;
    Enable = 1'b0;
    LzEn   = 1'b0;
    model_reset();
    run(2);
    check_dark("reset_init");
    Reset = 1'b0;

    // Plain scan of 1234, then tear-free updates.
    load(16'h1234);
    tick();
    Enable = 1'b1;
    run(45);
    run(6);
    load(16'hABCD);
    run(50);
    load(16'h1111);
    run(3);
    load(16'h5A5A);
    run(45);

    // Asynchronous reset mid-frame, between clock edges.
    run(7);
    #2;
    Reset = 1'b1;
    #1;
    check_dark("reset_mid");
    run(2);
    Reset = 1'b0;
    model_reset();
    run(25);

    // Leading-zero suppression.
    LzEn = 1'b1;
    load(16'h0050);
    run(45);
    load(16'h0000);
    run(25);
    LzEn = 1'b0;
    run(25);

    // Drop Enable during the gap slot of the GAP=1 build, load while idle, re-enable.
    load(16'h4321);
    run(22);
    for (int k = 0; k < 10 && !(m_t[0] % 5 == 4); k++) tick();
    chk("gap_slot_reached", m_t[0] % 5, 4);
    Enable = 1'b0;
    run(3);
    load(16'h9876);
    Enable = 1'b1;
    run(30);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      Enable = ($urandom_range(0, 40) != 0);
      if ($urandom_range(0, 200) == 0) LzEn = ~LzEn;
      if ($urandom_range(0, 11) == 0) begin
        rv = 16'($urandom);
        for (int k = 0; k < 4; k++) if ($urandom_range(0, 1) == 0) rv[4*k +: 4] = 4'h0;
        Value = rv;
        Load  = 1'b1;
      end
      tick();
    end

    Enable = 1'b0;
    run(4);
    chk("queue_empty_gap", q0.size(), 0);
    chk("queue_empty_nogap", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
